// File: rtl/sub_seq.sv
// Multi-word subtract sequencer: one N-bit subtract slice per cycle, LS word first,
// with a registered borrow (as carry) chained between slices.
module sub_seq #(
  parameter int unsigned N     = 2,
  parameter int unsigned WORDS = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [N*WORDS-1:0] I0,
  input  logic [N*WORDS-1:0] I1,
  input  logic               BIN,
  output logic [N*WORDS-1:0] O,
  output logic               COUT,
  output logic               EQ,
  output logic               done_valid,
  input  logic               done_ready
);

  localparam int unsigned W    = N * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [W-1:0]    a_q, a_d, b_q, b_d, o_q, o_d;
  logic            carry_q, carry_d, cout_q, cout_d, eq_q, eq_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [31:0]  base;
  logic [N-1:0] a_word, b_word;
  logic [N:0]   slice_sum;
  logic         last_word;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign last_word = (idx_q == IdxW'(WORDS - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_valid) state_d = StRun;
      StRun:  if (last_word) state_d = StDone;
      StDone: if (done_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    start_ready = 1'b0;
    done_valid  = 1'b0;
    unique case (state_q)
      StIdle:  start_ready = 1'b1;
      StDone:  done_valid  = 1'b1;
      default: ;
    endcase
  end

  // Subtraction as A + ~B + carry, where carry = ~borrow.
  assign base      = 32'(idx_q) * N;
  assign a_word    = a_q[base +: N];
  assign b_word    = b_q[base +: N];
  assign slice_sum = {1'b0, a_word} + {1'b0, ~b_word} + {{N{1'b0}}, carry_q};

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    o_d     = o_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    eq_d    = eq_q;
    idx_d   = idx_q;
    if (state_q == StIdle && start_valid) begin
      a_d     = I0;
      b_d     = I1;
      carry_d = ~BIN;
      idx_d   = '0;
    end else if (state_q == StRun) begin
      o_d[base +: N] = slice_sum[N-1:0];
      carry_d        = slice_sum[N];
      idx_d          = idx_q + IdxW'(1);
      if (last_word) begin
        cout_d = slice_sum[N];
        eq_d   = (o_d == '0) && slice_sum[N];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a_q     <= '0;
      b_q     <= '0;
      o_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      eq_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      o_q     <= o_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      eq_q    <= eq_d;
      idx_q   <= idx_d;
    end
  end

  assign O    = o_q;
  assign COUT = cout_q;
  assign EQ   = eq_q;

endmodule

// File: tb/tb_sub_seq.sv
// Directed bench for sub_seq with N=2, WORDS=4 (8-bit operands).
module tb_sub_seq;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] I0 = 8'h00;
  logic [7:0] I1 = 8'h00;
  logic       BIN = 1'b0;
  logic [7:0] O;
  logic       COUT;
  logic       EQ;
  logic       done_valid;
  logic       done_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  sub_seq #(.N(2), .WORDS(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .I0         (I0),
    .I1         (I1),
    .BIN        (BIN),
    .O          (O),
    .COUT       (COUT),
    .EQ         (EQ),
    .done_valid (done_valid),
    .done_ready (done_ready)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Accept one operation and wait for done_valid; lat counts edges after accept.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input bit scramble, output int lat);
    I0 = a;
    I1 = b;
    BIN = bin;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    if (scramble) begin
      I0 = ~a;
      I1 = a ^ 8'h5C;
      BIN = ~bin;
    end
    lat = 0;
    while (!done_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_done();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({O, COUT, EQ, done_valid, start_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got O=%h COUT=%b EQ=%b dv=%b sr=%b, want 00 0 0 0 1",
               O, COUT, EQ, done_valid, start_ready);
    end
  endtask

  task automatic test_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input bit scramble, input logic [7:0] exp_o,
                         input logic exp_c, input logic exp_eq);
    int lat;
    launch(a, b, bin, scramble, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL %s_latency: got %0d edges, want 4", name, lat);
    end
    n_cmp++;
    if ({O, COUT, EQ} !== {exp_o, exp_c, exp_eq}) begin
      n_err++;
      $display("FAIL %s_result: got O=%h COUT=%b EQ=%b, want O=%h COUT=%b EQ=%b",
               name, O, COUT, EQ, exp_o, exp_c, exp_eq);
    end
    release_done();
    n_cmp++;
    if ({start_ready, done_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL %s_handshake: got sr=%b dv=%b, want 1 0", name, start_ready, done_valid);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    launch(8'h5A, 8'h23, 1'b0, 1'b0, lat);
    start_valid = 1'b1;
    I0 = 8'hFF;
    I1 = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({O, COUT, EQ, done_valid, start_ready} !== {8'h37, 1'b1, 1'b0, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL backpressure_hold%0d: got O=%h C=%b EQ=%b dv=%b sr=%b, want 37 1 0 1 0",
                 i, O, COUT, EQ, done_valid, start_ready);
      end
    end
    start_valid = 1'b0;
    release_done();
    n_cmp++;
    if ({start_ready, done_valid, O} !== {1'b1, 1'b0, 8'h37}) begin
      n_err++;
      $display("FAIL backpressure_release: got sr=%b dv=%b O=%h, want 1 0 37",
               start_ready, done_valid, O);
    end
  endtask

  task automatic test_mid_run_reset();
    bit saw_dv;
    I0 = 8'h5A;
    I1 = 8'h23;
    BIN = 1'b0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    RESET = 1'b1;
    #1;
    n_cmp++;
    if ({O, COUT, done_valid, start_ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL midrun_reset: got O=%h COUT=%b dv=%b sr=%b, want 00 0 0 1",
               O, COUT, done_valid, start_ready);
    end
    #2;
    RESET = 1'b0;
    saw_dv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_valid) saw_dv = 1'b1;
    end
    n_cmp++;
    if (saw_dv !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_no_done: got done_valid pulse=%b, want 0", saw_dv);
    end
    test_op("after_reset", 8'h5A, 8'h23, 1'b0, 1'b0, 8'h37, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int acc[2];
    int n_acc = 0;
    int done_edge = -1;
    logic sr, dv;
    I0 = 8'h5A;
    I1 = 8'h23;
    BIN = 1'b0;
    start_valid = 1'b1;
    done_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && n_acc < 2; cyc++) begin
      sr = start_ready;
      dv = done_valid;
      if (dv && done_edge < 0) begin
        n_cmp++;
        if ({O, COUT} !== {8'h37, 1'b1}) begin
          n_err++;
          $display("FAIL b2b_result: got O=%h COUT=%b, want 37 1", O, COUT);
        end
      end
      tick();
      if (sr) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      if (dv && done_edge < 0) done_edge = cyc;
    end
    start_valid = 1'b0;
    n_cmp++;
    if (n_acc !== 2) begin
      n_err++;
      $display("FAIL b2b_accepts: got %0d accepts, want 2", n_acc);
    end else begin
      n_cmp++;
      if (acc[1] - acc[0] !== 6) begin
        n_err++;
        $display("FAIL b2b_period: got %0d cycles, want 6", acc[1] - acc[0]);
      end
      n_cmp++;
      if (acc[1] !== done_edge + 1) begin
        n_err++;
        $display("FAIL b2b_next_accept: got edge %0d, want %0d", acc[1], done_edge + 1);
      end
    end
    for (int i = 0; i < 8; i++) tick();
    done_ready = 1'b0;
  endtask

  initial begin
    #12;
    test_reset();
    RESET = 1'b0;
    tick();
    test_op("basic", 8'h5A, 8'h23, 1'b0, 1'b0, 8'h37, 1'b1, 1'b0);
    test_op("borrow", 8'h10, 8'h20, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0);
    test_op("bin_only", 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    test_op("equal", 8'h42, 8'h42, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    test_op("scramble", 8'h42, 8'h42, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    test_backpressure();
    test_mid_run_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sub_seq.md
# sub_seq

Multi-word subtract sequencer that computes a W-bit difference by driving one N-bit carry-chain subtract slice once per cycle, least-significant word first, with a registered borrow between slices. It sits between a requester issuing wide subtract/compare operations and the narrow Spartan-6 carry-chain subtractor. It trades latency (WORDS cycles) for a single shared slice. Operands are captured on a valid/ready start handshake, and the result is presented on a valid/ready done handshake.

## Interface
- N, 2, slice width in bits (N >= 1)
- WORDS, 4, number of slices per operation (WORDS >= 1); W = N*WORDS
- CLK  input  1  clock, all state updates on rising edge
- RESET  input  1  asynchronous, active-high reset
- start_valid  input  1  requester presents an operation
- start_ready  output  1  block accepts an operation (high only in IDLE)
- I0  input  W  minuend, sampled on start handshake
- I1  input  W  subtrahend, sampled on start handshake
- BIN  input  1  borrow-in, sampled on start handshake
- O  output  W  difference register (I0 - I1 - BIN) mod 2^W
- COUT  output  1  carry-out of final slice; 1 = no borrow (I0 >= I1 + BIN)
- EQ  output  1  1 when O == 0 and COUT == 1
- done_valid  output  1  O/COUT/EQ hold a completed result
- done_ready  input  1  consumer takes the result

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - start_ready=1, done_valid=0.
  - On start_valid=1 at an edge: capture I0->A, I1->B, carry <= ~BIN, idx <= 0, go RUN.
- RUN:
  - start_ready=0, done_valid=0.
  - Each edge: {c, s} = A[idx] + ~B[idx] + carry, with N-bit slices and c the slice carry-out.
  - O word idx <= s; carry <= c; idx <= idx+1.
  - On the edge processing idx == WORDS-1, COUT <= c and the state goes to DONE.
- DONE:
  - done_valid=1; O, COUT and EQ are held stable.
  - On done_ready=1 at an edge, go IDLE.
  - start_valid is ignored while in DONE.
- O is written word by word during RUN. Its value is only meaningful while done_valid=1.
- EQ is registered and computed from the final O and COUT.
- idx counter width is max(1, clog2(WORDS)). For WORDS=1, RUN lasts exactly one cycle.
- Operand registers A and B are unchanged during RUN. Input changes after capture have no effect.

## Timing
- Reset values:
  - state=IDLE, O=0, COUT=0, EQ=0, carry=0, idx=0.
  - done_valid=0, start_ready=1 (start_ready is combinational from state).
- RESET asserted in any state, including mid-RUN or DONE:
  - Immediately forces reset values and abandons the operation.
  - No done_valid pulse follows.
- Latency: accept at edge t0; slices processed at edges t0+1 .. t0+WORDS; done_valid=1 from edge t0+WORDS.
- Done handshake at edge t1 -> IDLE. start_ready=1 from t1, so the earliest next accept is edge t1+1.
- Start and done handshakes cannot be simultaneous, because start_ready and done_valid are mutually exclusive.
- Throughput: one operation per WORDS+2 cycles with both sides always ready.
- done_ready held low: DONE persists indefinitely with outputs stable.

## Test plan
- N=2, WORDS=4, I0=0x5A, I1=0x23, BIN=0 -> O=0x37, COUT=1, EQ=0; done_valid rises exactly 4 edges after accept.
- I0=0x10, I1=0x20, BIN=0 -> O=0xF0, COUT=0, EQ=0. I0=0x00, I1=0x00, BIN=1 -> O=0xFF, COUT=0.
- I0=0x42, I1=0x42, BIN=0 -> O=0x00, COUT=1, EQ=1. Change I0/I1 during RUN -> result unchanged.
- Backpressure: hold done_ready=0 for 5 cycles with start_valid=1 -> O/COUT/EQ stable, start_ready=0, no new capture; release -> IDLE.
- Assert RESET at the second RUN cycle -> O=0, COUT=0, done_valid=0, start_ready=1. A following 0x5A-0x23 operation completes correctly as 0x37.
- Back-to-back: start_valid held high, done_ready=1 -> second accept occurs one edge after the done handshake; period = 6 cycles.
